register_file_scoreboard: RTL and testbench
===========================================

# register_file_scoreboard

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, for the pipelined Yu core. It replaces the fixed 2-read / 32x32 single-cycle register file. Reads are posedge-registered with one-cycle latency; x0 stays hardwired to zero. A busy bit per register tells the issue stage whether an operand is still owed by an in-flight instruction.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- REGISTER_NUM, 32, number of architectural registers (power of two, ≥2)
- ADDR_WIDTH, 5, register address width; must equal log2(REGISTER_NUM)
- READ_PORTS, 2, number of independent read ports (1..4)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- readEnable  input  READ_PORTS  per-port read strobe
- readAddr  input  READ_PORTS*ADDR_WIDTH  port p address at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- readData  output  READ_PORTS*DATA_WIDTH  port p data at bits [p*DATA_WIDTH +: DATA_WIDTH]
- readBusy  output  READ_PORTS  port p: addressed register had a pending write when sampled
- writeEnable  input  1  commit write strobe
- writeRegister  input  ADDR_WIDTH  destination of commit write
- writeData  input  DATA_WIDTH  commit write data
- reserveEnable  input  1  mark a register as pending (instruction issued)
- reserveRegister  input  ADDR_WIDTH  register to mark pending
- flushBusy  input  1  clear all busy bits (pipeline flush)
- busyVector  output  REGISTER_NUM  live busy bits, bit i = register i

## Operation
- Storage: REGISTER_NUM x DATA_WIDTH array plus REGISTER_NUM busy bits.
- Write: on rising edge with writeEnable=1 and writeRegister≠0, array[writeRegister] ← writeData and busy[writeRegister] ← 0. Writes to x0 are discarded.
- Reserve: on rising edge with reserveEnable=1 and reserveRegister≠0, busy[reserveRegister] ← 1. Reserving x0 has no effect; busy[0] is constant 0.
- Reserve and write to the same register on the same edge: busy ends 1 (the new owner wins); the data is still written.
- flushBusy=1: all busy bits ← 0 on that edge. Flush has priority over a same-edge reserve. A same-edge write still updates data.
- Read port p with readEnable[p]=1: on the edge, readData[p] ← array[readAddr[p]] and readBusy[p] ← busy[readAddr[p]]. Address 0 always returns 0 and not-busy.
- Read port p with readEnable[p]=0: readData[p] and readBusy[p] hold their previous values.
- Ports are fully independent. Several ports may read the same address in the same cycle.
- Out-of-range addresses cannot occur, because ADDR_WIDTH = log2(REGISTER_NUM).

## Timing
- Reset (async assert, applies immediately): all array entries 0, all busy bits 0, readData 0, readBusy 0, busyVector 0.
- Release of rst is synchronised by the environment. The first functional edge is the first rising edge after rst falls.
- Read latency is 1 cycle: an address presented before edge N gives readData/readBusy valid after edge N, stable through edge N+1.
- Write-to-array latency is 1 edge. A read issued one cycle after the write edge always sees the new data.
- busyVector is a direct register output. It reflects reserve, write and flush effects after the edge that applies them.
- Same-edge read and write to the same non-zero address is controlled by the configuration macro below.

## Configuration
- REGFILE_BYPASS_EN defined (write-first):
  - A read on the same edge as a matching write returns writeData.
  - readBusy is returned as 0 unless a same-edge reserve hits the same register, in which case it is 1.
  - The forwarding mux is per port.
- REGFILE_BYPASS_EN undefined (read-first): such a read returns the old array value and the pre-edge busy bit. No forwarding logic is built.

## Test plan
- Reset: assert rst mid-run after writing x5=0xDEADBEEF → immediately all readData=0, busyVector=0; after release, read x5 → 0.
- x0: write 0xFFFFFFFF to x0 and reserve x0 → a later read of x0 returns 0 with readBusy=0; busyVector[0]=0.
- Scoreboard: reserve x7, then read x7 → readBusy=1. Write x7=0x12345678, then read next cycle → data 0x12345678, readBusy=0. Reserve x9 and write x9 on the same edge → busyVector[9]=1.
- Flush: reserve x3, x4, x31, then flushBusy alongside reserve x6 → busyVector=0 after the edge.
- Bypass: write x10=0xA5A5A5A5 while port 1 reads x10 and x10 previously held 0x1 → readData[1]=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without.
- Multi-port/hold: READ_PORTS=4, DATA_WIDTH=64; all ports read distinct registers → each gets correct data. Deassert readEnable[2] and change its address → readData[2] unchanged.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - multi-read-port register file with per-register pending-write scoreboard
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding on same-edge read/write of one register).
// Without it the file is read-first: a same-edge read sees the old data and the pre-edge busy bit.
module register_file_scoreboard #(
    parameter int DATA_WIDTH   = 32,
    parameter int REGISTER_NUM = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_PORTS   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [READ_PORTS-1:0]            readEnable,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [READ_PORTS-1:0]            readBusy,
    input  logic                             writeEnable,
    input  logic [ADDR_WIDTH-1:0]            writeRegister,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             reserveEnable,
    input  logic [ADDR_WIDTH-1:0]            reserveRegister,
    input  logic                             flushBusy,
    output logic [REGISTER_NUM-1:0]          busyVector
);

    logic [DATA_WIDTH-1:0]   regArray [REGISTER_NUM];
    logic [REGISTER_NUM-1:0] busy;
    logic [REGISTER_NUM-1:0] busyNext;
    logic [ADDR_WIDTH-1:0]   portAddr [READ_PORTS];
    logic [DATA_WIDTH-1:0]   portData [READ_PORTS];
    logic [READ_PORTS-1:0]   portBusy;
    logic                    writeValid;
    logic                    reserveValid;

    // x0 is never a legal destination, so both strobes are qualified against it once here.
    assign writeValid   = writeEnable && (writeRegister != '0);
    assign reserveValid = reserveEnable && (reserveRegister != '0);
    assign busyVector   = busy;

    generate
        for (genvar g = 0; g < READ_PORTS; g++) begin : gAddr
            assign portAddr[g] = readAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Scoreboard next state: commit clears, reserve sets afterwards (the new owner wins), flush clears all.
    always_comb begin
        busyNext = busy;
        if (writeValid) begin
            busyNext[writeRegister] = 1'b0;
        end
        if (reserveValid) begin
            busyNext[reserveRegister] = 1'b1;
        end
        if (flushBusy) begin
            busyNext = '0;
        end
        busyNext[0] = 1'b0;
    end

    // Per-port lookup value captured on the next edge; address 0 always reads as zero and not busy.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            portData[p] = regArray[portAddr[p]];
            portBusy[p] = busy[portAddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (writeValid && (writeRegister == portAddr[p])) begin
                portData[p] = writeData;
                portBusy[p] = reserveValid && (reserveRegister == portAddr[p]);
            end
`endif
            if (portAddr[p] == '0) begin
                portData[p] = '0;
                portBusy[p] = 1'b0;
            end
        end
    end

    // Busy bits register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // Register array commit write; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGISTER_NUM; i++) begin
                regArray[i] <= '0;
            end
        end else if (writeValid) begin
            regArray[writeRegister] <= writeData;
        end
    end

    // Registered read ports; a disabled port holds its last data and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readData <= '0;
            readBusy <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (readEnable[p]) begin
                    readData[p*DATA_WIDTH +: DATA_WIDTH] <= portData[p];
                    readBusy[p]                          <= portBusy[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - self-checking bench for register_file_scoreboard
module tb_register_file_scoreboard;

    localparam int DW = 64;
    localparam int RN = 32;
    localparam int AW = 5;
    localparam int RP = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [RP-1:0]    readEnable;
    logic [RP*AW-1:0] readAddr;
    logic [RP*DW-1:0] readData;
    logic [RP-1:0]    readBusy;
    logic             writeEnable;
    logic [AW-1:0]    writeRegister;
    logic [DW-1:0]    writeData;
    logic             reserveEnable;
    logic [AW-1:0]    reserveRegister;
    logic             flushBusy;
    logic [RN-1:0]    busyVector;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    // Reference model: architectural contents, pending flags and last value latched per port.
    logic [DW-1:0] mMem [RN];
    bit            mBusy [RN];
    logic [DW-1:0] mRd [RP];
    bit            mRb [RP];

    typedef struct {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] rr;
        logic          fl;
        logic          en0;
        logic [AW-1:0] a0;
        logic [DW-1:0] expD0;
        logic          expB0;
        logic [RN-1:0] expBv;
    } vec_t;

    vec_t tbl [13];

    register_file_scoreboard #(
        .DATA_WIDTH  (DW),
        .REGISTER_NUM(RN),
        .ADDR_WIDTH  (AW),
        .READ_PORTS  (RP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .readEnable     (readEnable),
        .readAddr       (readAddr),
        .readData       (readData),
        .readBusy       (readBusy),
        .writeEnable    (writeEnable),
        .writeRegister  (writeRegister),
        .writeData      (writeData),
        .reserveEnable  (reserveEnable),
        .reserveRegister(reserveRegister),
        .flushBusy      (flushBusy),
        .busyVector     (busyVector)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, logic [AW-1:0] wr, logic [DW-1:0] wd, logic re,
                                logic [AW-1:0] rr, logic fl, logic en0, logic [AW-1:0] a0,
                                logic [DW-1:0] expD0, logic expB0, logic [RN-1:0] expBv);
        vec_t v;
        v.we = we; v.wr = wr; v.wd = wd; v.re = re; v.rr = rr; v.fl = fl;
        v.en0 = en0; v.a0 = a0; v.expD0 = expD0; v.expB0 = expB0; v.expBv = expBv;
        return v;
    endfunction

    task automatic check(input string name, input logic [RP*DW-1:0] act, input logic [RP*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cycleNo, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < RN; i++) begin
            mMem[i]  = '0;
            mBusy[i] = 1'b0;
        end
        for (int p = 0; p < RP; p++) begin
            mRd[p] = '0;
            mRb[p] = 1'b0;
        end
    endtask

    task automatic idle();
        readEnable      = '0;
        readAddr        = '0;
        writeEnable     = 1'b0;
        writeRegister   = '0;
        writeData       = '0;
        reserveEnable   = 1'b0;
        reserveRegister = '0;
        flushBusy       = 1'b0;
    endtask

    task automatic checkModel();
        logic [RP*DW-1:0] expD;
        logic [RP-1:0]    expB;
        logic [RN-1:0]    expV;
        for (int p = 0; p < RP; p++) begin
            expD[p*DW +: DW] = mRd[p];
            expB[p]          = mRb[p];
        end
        for (int i = 0; i < RN; i++) expV[i] = mBusy[i];
        check("model_readData", readData, expD);
        check("model_readBusy", {{(RP*DW-RP){1'b0}}, readBusy}, {{(RP*DW-RP){1'b0}}, expB});
        check("model_busyVector", {{(RP*DW-RN){1'b0}}, busyVector}, {{(RP*DW-RN){1'b0}}, expV});
    endtask

    // Advance the model by one edge from the currently driven inputs, clock the DUT, then compare.
    task automatic doCycle();
        logic [AW-1:0] a;
        for (int p = 0; p < RP; p++) begin
            if (readEnable[p]) begin
                a = readAddr[p*AW +: AW];
                if (a == 0) begin
                    mRd[p] = '0;
                    mRb[p] = 1'b0;
                end
`ifdef REGFILE_BYPASS_EN
                else if (writeEnable && writeRegister == a) begin
                    mRd[p] = writeData;
                    mRb[p] = reserveEnable && (reserveRegister == a);
                end
`endif
                else begin
                    mRd[p] = mMem[a];
                    mRb[p] = mBusy[a];
                end
            end
        end
        if (writeEnable && writeRegister != 0) mMem[writeRegister] = writeData;
        if (flushBusy) begin
            for (int i = 0; i < RN; i++) mBusy[i] = 1'b0;
        end else begin
            if (writeEnable && writeRegister != 0) mBusy[writeRegister] = 1'b0;
            if (reserveEnable && reserveRegister != 0) mBusy[reserveRegister] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cycleNo++;
        checkModel();
    endtask

    task automatic setRead(input int p, input logic en, input logic [AW-1:0] addr);
        readEnable[p]          = en;
        readAddr[p*AW +: AW]   = addr;
    endtask

    task automatic doWrite(input logic [AW-1:0] r, input logic [DW-1:0] d);
        idle();
        writeEnable   = 1'b1;
        writeRegister = r;
        writeData     = d;
        doCycle();
    endtask

    initial begin
        // Directed scoreboard sequence, reading through port 0.
        //            we  wr  wd                      re  rr  fl en0 a0  expD0                   B0  expBv
        tbl[0]  = mk(1, 0,  64'hFFFFFFFFFFFFFFFF,    1,  0,  0, 0,  0,  64'h0,                  0,  32'h0);
        tbl[1]  = mk(0, 0,  64'h0,                   0,  0,  0, 1,  0,  64'h0,                  0,  32'h0);
        tbl[2]  = mk(0, 0,  64'h0,                   1,  7,  0, 0,  0,  64'h0,                  0,  32'h0000_0080);
        tbl[3]  = mk(0, 0,  64'h0,                   0,  0,  0, 1,  7,  64'h0,                  1,  32'h0000_0080);
        tbl[4]  = mk(1, 7,  64'h12345678,            0,  0,  0, 0,  7,  64'h0,                  1,  32'h0);
        tbl[5]  = mk(0, 0,  64'h0,                   0,  0,  0, 1,  7,  64'h12345678,           0,  32'h0);
        tbl[6]  = mk(1, 9,  64'h55,                  1,  9,  0, 0,  0,  64'h12345678,           0,  32'h0000_0200);
        tbl[7]  = mk(0, 0,  64'h0,                   0,  0,  0, 1,  9,  64'h55,                 1,  32'h0000_0200);
        tbl[8]  = mk(0, 0,  64'h0,                   1,  3,  0, 0,  0,  64'h55,                 1,  32'h0000_0208);
        tbl[9]  = mk(0, 0,  64'h0,                   1,  4,  0, 0,  0,  64'h55,                 1,  32'h0000_0218);
        tbl[10] = mk(0, 0,  64'h0,                   1,  31, 0, 0,  0,  64'h55,                 1,  32'h8000_0218);
        tbl[11] = mk(0, 0,  64'h0,                   1,  6,  1, 1,  31, 64'h0,                  1,  32'h0);
        tbl[12] = mk(0, 0,  64'h0,                   0,  0,  0, 1,  31, 64'h0,                  0,  32'h0);

        idle();
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkModel();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            idle();
            writeEnable     = tbl[i].we;
            writeRegister   = tbl[i].wr;
            writeData       = tbl[i].wd;
            reserveEnable   = tbl[i].re;
            reserveRegister = tbl[i].rr;
            flushBusy       = tbl[i].fl;
            setRead(0, tbl[i].en0, tbl[i].a0);
            doCycle();
            check($sformatf("tbl%0d_readData0", i), {{(RP*DW-DW){1'b0}}, readData[DW-1:0]},
                  {{(RP*DW-DW){1'b0}}, tbl[i].expD0});
            check($sformatf("tbl%0d_readBusy0", i), {{(RP*DW-1){1'b0}}, readBusy[0]},
                  {{(RP*DW-1){1'b0}}, tbl[i].expB0});
            check($sformatf("tbl%0d_busyVector", i), {{(RP*DW-RN){1'b0}}, busyVector},
                  {{(RP*DW-RN){1'b0}}, tbl[i].expBv});
        end

        // Same-edge read and write of x10 on port 1.
        doWrite(10, 64'h1);
        idle();
        writeEnable = 1'b1; writeRegister = 10; writeData = 64'hA5A5A5A5;
        setRead(1, 1'b1, 10);
        doCycle();
`ifdef REGFILE_BYPASS_EN
        check("bypass_data", {{(RP*DW-DW){1'b0}}, readData[DW +: DW]}, {{(RP*DW-DW){1'b0}}, 64'hA5A5A5A5});
`else
        check("bypass_data", {{(RP*DW-DW){1'b0}}, readData[DW +: DW]}, {{(RP*DW-DW){1'b0}}, 64'h1});
`endif
        idle();
        writeEnable = 1'b1; writeRegister = 10; writeData = 64'h77;
        reserveEnable = 1'b1; reserveRegister = 10;
        setRead(1, 1'b1, 10);
        doCycle();
`ifdef REGFILE_BYPASS_EN
        check("bypass_reserve_busy", {{(RP*DW-1){1'b0}}, readBusy[1]}, {{(RP*DW-1){1'b0}}, 1'b1});
`else
        check("bypass_reserve_busy", {{(RP*DW-1){1'b0}}, readBusy[1]}, {{(RP*DW-1){1'b0}}, 1'b0});
`endif

        // All four ports read distinct registers, then port 2 is disabled and re-addressed.
        for (int r = 1; r <= 4; r++) doWrite(AW'(r), 64'hC0DE_0000_0000_0000 | 64'(r));
        idle();
        for (int p = 0; p < RP; p++) setRead(p, 1'b1, AW'(p + 1));
        doCycle();
        for (int p = 0; p < RP; p++)
            check($sformatf("multiport_p%0d", p), {{(RP*DW-DW){1'b0}}, readData[p*DW +: DW]},
                  {{(RP*DW-DW){1'b0}}, 64'hC0DE_0000_0000_0000 | 64'(p + 1)});
        readEnable = 4'b1011;
        readAddr[2*AW +: AW] = 5'd10;
        readAddr[0 +: AW]    = 5'd4;
        doCycle();
        check("hold_p2", {{(RP*DW-DW){1'b0}}, readData[2*DW +: DW]},
              {{(RP*DW-DW){1'b0}}, 64'hC0DE_0000_0000_0003});
        check("newread_p0", {{(RP*DW-DW){1'b0}}, readData[0 +: DW]},
              {{(RP*DW-DW){1'b0}}, 64'hC0DE_0000_0000_0004});

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            writeEnable     = 1'($urandom);
            writeRegister   = AW'($urandom);
            writeData       = {$urandom, $urandom};
            reserveEnable   = 1'($urandom);
            reserveRegister = AW'($urandom);
            flushBusy       = ($urandom_range(0, 15) == 0);
            readEnable      = RP'($urandom);
            readAddr        = (RP*AW)'($urandom);
            doCycle();
        end

        // Asynchronous reset mid-run after x5 has been written and read back.
        doWrite(5, 64'hDEADBEEF);
        idle();
        for (int p = 0; p < RP; p++) setRead(p, 1'b1, 5);
        reserveEnable = 1'b1; reserveRegister = 12;
        doCycle();
        idle();
        #2 rst = 1'b1;
        #1;
        modelReset();
        check("reset_readData", readData, '0);
        check("reset_readBusy", {{(RP*DW-RP){1'b0}}, readBusy}, '0);
        check("reset_busyVector", {{(RP*DW-RN){1'b0}}, busyVector}, '0);
        @(negedge clk);
        rst = 1'b0;
        setRead(0, 1'b1, 5);
        doCycle();
        check("after_reset_x5", {{(RP*DW-DW){1'b0}}, readData[DW-1:0]}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
